pc_sequencer: RTL
=================

# pc_sequencer

Program-counter sequencer for the 11-bit PIC-style core. It generates the instruction fetch address, executes CALL/GOTO/RETURN/computed-goto/skip control transfers, and squashes the already-fetched instruction after every taken transfer. It sits directly upstream of the 16-entry hardware return stack: it drives the stack's data input and push/pop strobes and consumes the stack's top-of-stack output. It also tracks stack depth and raises sticky overflow and underflow flags.

## Interface
Parameters:
- ADDR_W, 11, program address width; must match the stack data width.
- STK_DEPTH, 16, return-stack entries; the depth counter is $clog2(STK_DEPTH)+1 bits.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- op_call  in  1  decoded CALL in the decode stage.
- op_goto  in  1  decoded GOTO.
- op_return  in  1  decoded RETURN/RETLW/RETFIE.
- op_skip  in  1  conditional skip whose condition is true (BTFSS/DECFSZ etc.).
- pcl_write  in  1  ALU write to PCL (computed goto).
- target  in  ADDR_W  CALL/GOTO destination from the instruction word.
- pcl_data  in  8  value written to PCL.
- pclath  in  5  PCLATH register; bits [2:0] form PC[10:8] on a computed goto.
- flag_clr  in  1  clears the sticky overflow and underflow flags.
- stack_out  in  ADDR_W  top-of-stack from the stack, combinational.
- stack_in  out  ADDR_W  return address to the stack.
- push  out  1  stack push strobe.
- pop  out  1  stack pop strobe.
- pc  out  ADDR_W  current fetch address.
- flush  out  1  1 = the instruction now in decode is squashed (executes as NOP).
- stk_depth  out  5  number of valid stack entries, 0..16.
- stk_ovf  out  1  sticky: push was issued at depth 16.
- stk_unf  out  1  sticky: pop was issued at depth 0.

## Operation
- Registers: pc, flush, stk_depth, stk_ovf, stk_unf.
- Reset values (reset=0): pc=0, flush=1, stk_depth=0, stk_ovf=0, stk_unf=0. push=0, pop=0, and stack_in=pc=0 while reset is asserted.
- Effective ops: every op_* and pcl_write input is gated by ~flush. While flush=1, all of them are ignored.
- One op wins per cycle, by priority: return > call > goto > pcl_write > skip.
- return: pop=1; next pc=stack_out; next flush=1.
- call: push=1; stack_in=pc (the address of the instruction after the CALL); next pc=target; next flush=1.
- goto: next pc=target; next flush=1.
- pcl_write: next pc={pclath[2:0], pcl_data}; next flush=1.
- skip: next pc=pc+1; next flush=1.
- No op: next pc=pc+1 (modulo 2^11; 0x7FF wraps to 0x000); next flush=0.
- Outputs push, pop and stack_in are combinational from the effective op. stack_in always equals pc.
- Depth on push:
  - depth<16: depth+1.
  - depth=16: depth stays 16, stk_ovf set, push still issued (the stack overwrites its oldest entry).
- Depth on pop:
  - depth>0: depth-1.
  - depth=0: depth stays 0, stk_unf set, pop still issued, pc still loads stack_out.
- Flags: flag_clr clears both flags. If a flag event occurs in the same cycle as flag_clr, the event wins and the flag is set.

## Timing
- The block models a two-stage fetch/decode pipeline. Every taken transfer costs 2 cycles: the transfer cycle plus one squashed slot.
- New pc is visible one cycle after the op is sampled.
- flush is high for exactly one cycle after each transfer, and for the first cycle after reset release.
- Pop timing: stack_out is sampled in the same cycle as pop. The stack pointer decrements at that edge.
- Push timing: stack_in is written at the push edge. The new top is visible on stack_out in the next cycle.
- Back-to-back transfers are impossible, because the slot after a transfer is always flushed.
- Asynchronous reset mid-operation (e.g. during a CALL cycle) clears everything at once. No push takes effect, because the stack itself is reset.
- Only one of push and pop is ever high.

## Test plan
- Reset and sequential fetch: release reset, no ops -> flush=1 in cycle 0; then pc=0,1,2,3...; flush=0 from cycle 1. Preload pc to 0x7FF -> next pc=0x000.
- CALL/RETURN round trip: pc=0x010, op_call with target=0x155 -> push=1, stack_in=0x010; next pc=0x155, flush=1; an op_return in the flushed cycle is ignored. Later op_return with stack_out=0x010 -> pop=1; next pc=0x010; stk_depth goes 0->1->0.
- Computed goto and skip: pclath=5'b00011, pcl_data=0xA4, pcl_write -> next pc=0x3A4, flush=1. op_skip at pc=0x020 -> next pc=0x021, flush=1, then pc=0x022.
- Priority: op_return, op_call and op_goto together -> only pop=1, pc=stack_out, push=0.
- Overflow and underflow: 17 CALLs (each followed by its flushed slot) -> stk_depth stays 16, stk_ovf=1 after the 17th. flag_clr -> stk_ovf=0. Reset, then op_return -> stk_unf=1, stk_depth=0.
- Async reset mid-CALL: drop reset between edges during a CALL cycle -> push=0, pc=0, flush=1 immediately; no depth change.

Source files
------------

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for the 11-bit PIC-style core. It produces the
// fetch address and executes control transfers: CALL, GOTO, RETURN, computed
// goto (PCL write) and skip. After every taken transfer it squashes the
// instruction that was already fetched. It drives the external hardware return
// stack (data, push, pop) and reads back that stack's combinational
// top-of-stack. It also keeps its own copy of the stack depth, together with
// sticky overflow and underflow flags.
//
// Parameters
//   ADDR_W     program address width; must equal the stack data width
//   STK_DEPTH  number of return-stack entries
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   op_call    in   decoded CALL
//   op_goto    in   decoded GOTO
//   op_return  in   decoded RETURN / RETLW / RETFIE
//   op_skip    in   conditional skip whose condition is true
//   pcl_write  in   ALU write to PCL (computed goto)
//   target     in   CALL/GOTO destination
//   pcl_data   in   byte written to PCL
//   pclath     in   PCLATH; [2:0] become PC[10:8] on a computed goto
//   flag_clr   in   clears the sticky overflow/underflow flags
//   stack_out  in   top-of-stack from the return stack
//   stack_in   out  return address pushed to the stack (always equals pc)
//   push       out  stack push strobe
//   pop        out  stack pop strobe
//   pc         out  current fetch address
//   flush      out  the instruction now in decode is squashed
//   stk_depth  out  number of valid stack entries
//   stk_ovf    out  sticky: push issued while the stack was full
//   stk_unf    out  sticky: pop issued while the stack was empty
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int ADDR_W    = 11,
  parameter int STK_DEPTH = 16,
  localparam int DEPTH_W  = $clog2(STK_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_call,
  input  logic               op_goto,
  input  logic               op_return,
  input  logic               op_skip,
  input  logic               pcl_write,
  input  logic [ADDR_W-1:0]  target,
  input  logic [7:0]         pcl_data,
  input  logic [4:0]         pclath,
  input  logic               flag_clr,
  input  logic [ADDR_W-1:0]  stack_out,
  output logic [ADDR_W-1:0]  stack_in,
  output logic               push,
  output logic               pop,
  output logic [ADDR_W-1:0]  pc,
  output logic               flush,
  output logic [DEPTH_W-1:0] stk_depth,
  output logic               stk_ovf,
  output logic               stk_unf
);

  // The single operation that wins this cycle.
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_RET  = 3'd1,
    OP_CALL = 3'd2,
    OP_GOTO = 3'd3,
    OP_PCL  = 3'd4,
    OP_SKIP = 3'd5
  } op_sel_t;

  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STK_DEPTH);

  // Next depth after at most one push or pop. The count saturates at both
  // ends, because the stack wraps on overflow and holds on underflow.
  function automatic logic [DEPTH_W-1:0] depth_next(
    input logic [DEPTH_W-1:0] depth,
    input logic               do_push,
    input logic               do_pop
  );
    logic [DEPTH_W-1:0] result;
    result = depth;
    if (do_push && (depth != DEPTH_FULL)) begin
      result = depth + DEPTH_W'(1);
    end else if (do_pop && (depth != {DEPTH_W{1'b0}})) begin
      result = depth - DEPTH_W'(1);
    end else begin
      result = depth;
    end
    return result;
  endfunction

  logic [ADDR_W-1:0]  r_pc;
  logic               r_flush;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_ovf;
  logic               r_unf;

  op_sel_t            w_op;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic               w_push;
  logic               w_pop;
  logic               w_ovf_ev;
  logic               w_unf_ev;
  logic               w_unused;

  // PCLATH[4:3] select program pages that this 2K core does not have.
  assign w_unused = ^pclath[4:3];

  // Priority select of the operation that wins. All ops are ignored while the
  // decode slot is flushed, because that slot holds a squashed instruction.
  always_comb begin
    w_op = OP_NONE;
    if (r_flush) begin
      w_op = OP_NONE;
    end else if (op_return) begin
      w_op = OP_RET;
    end else if (op_call) begin
      w_op = OP_CALL;
    end else if (op_goto) begin
      w_op = OP_GOTO;
    end else if (pcl_write) begin
      w_op = OP_PCL;
    end else if (op_skip) begin
      w_op = OP_SKIP;
    end else begin
      w_op = OP_NONE;
    end
  end

  // Next fetch address for the winning operation. A skip and a plain fetch
  // both advance by one; the skip differs only because it flushes decode.
  always_comb begin
    w_pc_nxt = r_pc + ADDR_W'(1);
    case (w_op)
      OP_RET:  w_pc_nxt = stack_out;
      OP_CALL: w_pc_nxt = target;
      OP_GOTO: w_pc_nxt = target;
      OP_PCL:  w_pc_nxt = ADDR_W'({pclath[2:0], pcl_data});
      OP_SKIP: w_pc_nxt = r_pc + ADDR_W'(1);
      default: w_pc_nxt = r_pc + ADDR_W'(1);
    endcase
  end

  assign w_push   = (w_op == OP_CALL);
  assign w_pop    = (w_op == OP_RET);
  // Push at full and pop at empty are still issued to the stack; they are
  // only recorded here.
  assign w_ovf_ev = w_push && (r_depth == DEPTH_FULL);
  assign w_unf_ev = w_pop  && (r_depth == {DEPTH_W{1'b0}});

  // Sequencer state: pc, flush slot, depth and sticky flags. Reset leaves
  // flush set so the first decode slot after reset release is squashed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= {ADDR_W{1'b0}};
      r_flush <= 1'b1;
      r_depth <= {DEPTH_W{1'b0}};
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_flush <= (w_op != OP_NONE);
      r_depth <= depth_next(r_depth, w_push, w_pop);
      // A new event beats a clear issued in the same cycle.
      r_ovf   <= w_ovf_ev | (r_ovf & ~flag_clr);
      r_unf   <= w_unf_ev | (r_unf & ~flag_clr);
    end
  end

  // The return address is the already-incremented pc, which is the address
  // of the instruction after the CALL.
  assign stack_in  = r_pc;
  assign push      = w_push;
  assign pop       = w_pop;
  assign pc        = r_pc;
  assign flush     = r_flush;
  assign stk_depth = r_depth;
  assign stk_ovf   = r_ovf;
  assign stk_unf   = r_unf;

endmodule
